// File: rtl/minesweeper_play_if.sv
`default_nettype none
// ============================================================================
// Module   : minesweeper_play_if
// Purpose  : Bundles the gameplay core's buttons, screen state and mine map
//            (into the core) with the cursor, revealed map and end status
//            (out of the core).
// Ports    : none; the signals are listed below.
//   button_i       5   button code (one-hot or NONE)
//   screen_state_i 3   current screen from the top-level FSM
//   map_i          W*H mine map, 1 = mine
//   x_pos_o        cursor column
//   y_pos_o        cursor row
//   play_end       2   00 playing, 01 lost, 10 won
//   map_shown_o    W*H revealed map, 1 = revealed
// Modports : master drives the inputs of the core, slave is the core itself.
// Revision : 1.0 - initial release
// ============================================================================
interface minesweeper_play_if #(
  parameter int MAP_HEIGHT = 8,
  parameter int MAP_WIDTH  = 8
);
  localparam int CELLS = MAP_HEIGHT * MAP_WIDTH;
  localparam int XW    = $clog2(MAP_WIDTH);
  localparam int YW    = $clog2(MAP_HEIGHT);

  logic [4:0]       button_i;
  logic [2:0]       screen_state_i;
  logic [CELLS-1:0] map_i;
  logic [XW-1:0]    x_pos_o;
  logic [YW-1:0]    y_pos_o;
  logic [1:0]       play_end;
  logic [CELLS-1:0] map_shown_o;

  modport master (
    output button_i, screen_state_i, map_i,
    input  x_pos_o, y_pos_o, play_end, map_shown_o
  );

  modport slave (
    input  button_i, screen_state_i, map_i,
    output x_pos_o, y_pos_o, play_end, map_shown_o
  );
endinterface
`default_nettype wire

// File: rtl/minesweeper_play.sv
`default_nettype none
// ============================================================================
// Module   : minesweeper_play
// Purpose  : Gameplay core of an 8x8 MineSweeper round. Owns the cursor, the
//            revealed-cell map and the win/lose status. Cell (x,y) is bit
//            y*MAP_WIDTH+x of every map vector.
// Ports    :
//   clk  in   system clock, all state on rising edge
//   rst  in   synchronous active-high reset
//   bus  slave modport of minesweeper_play_if (buttons, screen state, mine
//        map in; cursor, end status, revealed map out)
// Revision : 1.0 - initial release
// ============================================================================
module minesweeper_play #(
  parameter int MAP_HEIGHT = 8,
  parameter int MAP_WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  minesweeper_play_if.slave bus
);
  localparam int CELLS = MAP_HEIGHT * MAP_WIDTH;
  localparam int IW    = $clog2(CELLS);
  localparam int XW    = $clog2(MAP_WIDTH);
  localparam int YW    = $clog2(MAP_HEIGHT);

  localparam logic [XW-1:0] X_MAX = XW'(MAP_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(MAP_HEIGHT - 1);

  localparam logic [4:0] BTN_NONE  = 5'b00000;
  localparam logic [4:0] BTN_UP    = 5'b00001;
  localparam logic [4:0] BTN_DOWN  = 5'b00010;
  localparam logic [4:0] BTN_LEFT  = 5'b00100;
  localparam logic [4:0] BTN_RIGHT = 5'b01000;
  localparam logic [4:0] BTN_MID   = 5'b10000;

  localparam logic [2:0] SCR_START = 3'd0;
  localparam logic [2:0] SCR_PLAY  = 3'd1;

  localparam logic [1:0] END_PLAYING = 2'b00;
  localparam logic [1:0] END_LOST    = 2'b01;
  localparam logic [1:0] END_WON     = 2'b10;

  // Registered state
  logic [XW-1:0]    x_pos;
  logic [YW-1:0]    y_pos;
  logic [1:0]       end_state;
  logic [CELLS-1:0] shown;
  logic [4:0]       prev_button;

  // Next-state values
  logic [XW-1:0]    x_nxt;
  logic [YW-1:0]    y_nxt;
  logic [1:0]       end_nxt;
  logic [CELLS-1:0] shown_nxt;

  logic             btn_valid;
  logic             btn_fire;
  logic [IW-1:0]    cur_idx;
  logic [CELLS-1:0] cur_mask;
  logic [CELLS-1:0] expand;
  logic             nb_mine;
  logic [CELLS-1:0] nb_mask;
  logic             lose;

  // Only the five legal codes count; multi-hot and unused codes are dropped.
  always_comb begin
    btn_valid = 1'b0;
    case (bus.button_i)
      BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_MID: btn_valid = 1'b1;
      default:                                       btn_valid = 1'b0;
    endcase
  end

  // Rising edge from idle: one action per press, however long it is held.
  assign btn_fire = btn_valid && (prev_button == BTN_NONE);

  assign cur_idx = IW'(y_pos) * IW'(MAP_WIDTH) + IW'(x_pos);

  always_comb begin
    cur_mask          = '0;
    cur_mask[cur_idx] = 1'b1;
  end

  // Flood step: a revealed cell that is safe and has no mined neighbour
  // uncovers all of its in-map neighbours. Applied once per cycle, so the
  // revealed region grows by one ring per clock.
  always_comb begin
    expand  = '0;
    nb_mine = 1'b0;
    nb_mask = '0;
    for (int y = 0; y < MAP_HEIGHT; y++) begin
      for (int x = 0; x < MAP_WIDTH; x++) begin
        nb_mine = 1'b0;
        nb_mask = '0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if ((dx != 0 || dy != 0) &&
                (y + dy >= 0) && (y + dy < MAP_HEIGHT) &&
                (x + dx >= 0) && (x + dx < MAP_WIDTH)) begin
              nb_mine = nb_mine | bus.map_i[IW'((y + dy) * MAP_WIDTH + x + dx)];
              nb_mask[IW'((y + dy) * MAP_WIDTH + x + dx)] = 1'b1;
            end
          end
        end
        if (shown[IW'(y * MAP_WIDTH + x)] && !bus.map_i[IW'(y * MAP_WIDTH + x)] && !nb_mine)
          expand = expand | nb_mask;
      end
    end
  end

  // Play update while the round is live.
  always_comb begin
    x_nxt     = x_pos;
    y_nxt     = y_pos;
    end_nxt   = end_state;
    shown_nxt = shown;
    lose      = 1'b0;
    if (end_state == END_PLAYING) begin
      shown_nxt = shown | expand;
      if (btn_fire) begin
        case (bus.button_i)
          BTN_UP:    if (y_pos != '0)   y_nxt = y_pos - YW'(1);
          BTN_DOWN:  if (y_pos != Y_MAX) y_nxt = y_pos + YW'(1);
          BTN_LEFT:  if (x_pos != '0)   x_nxt = x_pos - XW'(1);
          BTN_RIGHT: if (x_pos != X_MAX) x_nxt = x_pos + XW'(1);
          BTN_MID: begin
            if (!shown[cur_idx]) begin
              if (bus.map_i[cur_idx]) begin
                // Stepping on a mine exposes every mine on the board.
                lose      = 1'b1;
                shown_nxt = shown_nxt | bus.map_i | cur_mask;
              end else begin
                shown_nxt = shown_nxt | cur_mask;
              end
            end
          end
          default: ;
        endcase
      end
      // Win looks at the current registered map, so it lands one cycle after
      // the last safe cell appears; a simultaneous lose wins the tie.
      if (lose)
        end_nxt = END_LOST;
      else if ((~bus.map_i & ~shown) == '0)
        end_nxt = END_WON;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.screen_state_i == SCR_START) begin
      x_pos       <= '0;
      y_pos       <= '0;
      end_state   <= END_PLAYING;
      shown       <= '0;
      prev_button <= BTN_NONE;
    end else if (bus.screen_state_i == SCR_PLAY) begin
      x_pos       <= x_nxt;
      y_pos       <= y_nxt;
      end_state   <= end_nxt;
      shown       <= shown_nxt;
      prev_button <= bus.button_i;
    end
    // Any other screen holds every register.
  end

  assign bus.x_pos_o     = x_pos;
  assign bus.y_pos_o     = y_pos;
  assign bus.play_end    = end_state;
  assign bus.map_shown_o = shown;
endmodule
`default_nettype wire

// File: tb/tb_minesweeper_play.sv
`default_nettype none
// ============================================================================
// Module   : tb_minesweeper_play
// Purpose  : Self-checking bench for minesweeper_play. A board-level model
//            (2-D revealed/mine arrays, cursor integers) is stepped on every
//            rising edge and compared with the DUT on every falling edge;
//            hand-computed literals pin key moments of each scenario.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_minesweeper_play;
  localparam logic [4:0] NONE  = 5'b00000;
  localparam logic [4:0] UP    = 5'b00001;
  localparam logic [4:0] DOWN  = 5'b00010;
  localparam logic [4:0] LEFT  = 5'b00100;
  localparam logic [4:0] RIGHT = 5'b01000;
  localparam logic [4:0] MID   = 5'b10000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  minesweeper_play_if #(.MAP_HEIGHT(8), .MAP_WIDTH(8)) bus ();

  minesweeper_play #(.MAP_HEIGHT(8), .MAP_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- board model ----------------
  int         mx, my;
  logic [1:0] mend;
  logic [4:0] mprev;
  bit         rev [8][8];
  bit         nxt [8][8];
  bit         mvalid = 1'b0;
  bit         mlose, mall;

  function automatic bit is_mine(int x, int y);
    if (x < 0 || x > 7 || y < 0 || y > 7) return 1'b0;
    return bus.map_i[6'(y * 8 + x)];
  endfunction

  function automatic bit is_zero(int x, int y);
    int n;
    n = 0;
    if (is_mine(x, y)) return 1'b0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (dx != 0 || dy != 0) n += int'(is_mine(x + dx, y + dy));
    return n == 0;
  endfunction

  always @(posedge clk) begin
    if (rst || bus.screen_state_i == 3'd0) begin
      mx = 0; my = 0; mend = 2'b00; mprev = NONE; mvalid = 1'b1;
      for (int x = 0; x < 8; x++)
        for (int y = 0; y < 8; y++) rev[x][y] = 1'b0;
    end else if (bus.screen_state_i == 3'd1) begin
      if (mend == 2'b00) begin
        nxt = rev;
        for (int x = 0; x < 8; x++)
          for (int y = 0; y < 8; y++)
            if (rev[x][y] && is_zero(x, y))
              for (int dy = -1; dy <= 1; dy++)
                for (int dx = -1; dx <= 1; dx++)
                  if (x + dx >= 0 && x + dx < 8 && y + dy >= 0 && y + dy < 8)
                    nxt[x + dx][y + dy] = 1'b1;
        mlose = 1'b0;
        if (mprev == NONE) begin
          case (bus.button_i)
            UP:    if (my > 0) my--;
            DOWN:  if (my < 7) my++;
            LEFT:  if (mx > 0) mx--;
            RIGHT: if (mx < 7) mx++;
            MID: begin
              if (!rev[mx][my]) begin
                nxt[mx][my] = 1'b1;
                if (is_mine(mx, my)) begin
                  mlose = 1'b1;
                  for (int x = 0; x < 8; x++)
                    for (int y = 0; y < 8; y++)
                      if (is_mine(x, y)) nxt[x][y] = 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
        mall = 1'b1;
        for (int x = 0; x < 8; x++)
          for (int y = 0; y < 8; y++)
            if (!is_mine(x, y) && !rev[x][y]) mall = 1'b0;
        if (mlose)     mend = 2'b01;
        else if (mall) mend = 2'b10;
        rev = nxt;
      end
      mprev = bus.button_i;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [63:0] mshown;
  always @(negedge clk) begin
    if (mvalid) begin
      for (int x = 0; x < 8; x++)
        for (int y = 0; y < 8; y++) mshown[6'(y * 8 + x)] = rev[x][y];
      total++;
      if (bus.x_pos_o !== 3'(mx) || bus.y_pos_o !== 3'(my) ||
          bus.play_end !== mend || bus.map_shown_o !== mshown) begin
        bad++;
        $display("FAIL model_cmp t=%0t: got x=%0d y=%0d end=%b shown=%h expected x=%0d y=%0d end=%b shown=%h",
                 $time, bus.x_pos_o, bus.y_pos_o, bus.play_end, bus.map_shown_o,
                 mx, my, mend, mshown);
      end
    end
  end

  // ---------------- literal checks and stimulus ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input logic [4:0] b);
    bus.button_i = b;
    @(negedge clk);
  endtask

  task automatic press(input logic [4:0] b);
    tick(b);
    tick(NONE);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_x"},     64'(bus.x_pos_o),  64'd0);
    check({tag, "_y"},     64'(bus.y_pos_o),  64'd0);
    check({tag, "_end"},   64'(bus.play_end), 64'd0);
    check({tag, "_shown"}, bus.map_shown_o,   64'd0);
  endtask

  initial begin
    bit got;
    rst                = 1'b1;
    bus.button_i       = NONE;
    bus.screen_state_i = 3'd0;
    bus.map_i          = 64'h6fcb_9f0a_b100_9080;
    @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);
    check_cleared("start");
    bus.screen_state_i = 3'd1;

    // Movement, invalid code, saturation, held button
    press(DOWN);
    press(5'b00011);
    press(RIGHT);
    check("move_x", 64'(bus.x_pos_o), 64'd1);
    check("move_y", 64'(bus.y_pos_o), 64'd1);
    press(LEFT); press(LEFT); press(LEFT);
    check("left_sat_x", 64'(bus.x_pos_o), 64'd0);
    repeat (5) tick(DOWN);
    tick(NONE);
    check("hold_down_y", 64'(bus.y_pos_o), 64'd2);

    // Flood from (1,1)
    press(UP);
    press(RIGHT);
    tick(MID);
    repeat (16) tick(NONE);
    check("flood_shown", bus.map_shown_o, 64'h0000_0000_0E0F_0F0F);
    check("flood_end",   64'(bus.play_end), 64'd0);

    // Single reveal then lose
    rst = 1'b1;
    tick(NONE);
    rst = 1'b0;
    press(RIGHT);
    press(DOWN); press(DOWN); press(DOWN);
    press(MID);
    tick(NONE);
    check("single_shown", bus.map_shown_o, 64'h0000_0000_0200_0000);
    press(DOWN);
    tick(MID);
    check("lose_end",   64'(bus.play_end), 64'd1);
    check("lose_shown", bus.map_shown_o, 64'h6fcb_9f0a_b300_9080);
    tick(NONE);
    press(MID); press(UP); press(LEFT);
    check("lose_hold_x",     64'(bus.x_pos_o),  64'd1);
    check("lose_hold_y",     64'(bus.y_pos_o),  64'd4);
    check("lose_hold_end",   64'(bus.play_end), 64'd1);
    check("lose_hold_shown", bus.map_shown_o, 64'h6fcb_9f0a_b300_9080);

    // New round: freeze, then win
    bus.screen_state_i = 3'd0;
    bus.map_i          = 64'h8000_0000_0000_0000;
    tick(NONE);
    bus.screen_state_i = 3'd1;
    press(RIGHT);
    bus.screen_state_i = 3'd2;
    press(DOWN); press(MID); press(LEFT);
    check("freeze_x",     64'(bus.x_pos_o),  64'd1);
    check("freeze_y",     64'(bus.y_pos_o),  64'd0);
    check("freeze_end",   64'(bus.play_end), 64'd0);
    check("freeze_shown", bus.map_shown_o,   64'd0);
    bus.screen_state_i = 3'd1;
    press(LEFT);
    tick(MID);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(NONE);
      if (bus.play_end == 2'b10) got = 1'b1;
    end
    check("win_end",   64'(bus.play_end), 64'd2);
    check("win_shown", bus.map_shown_o, 64'h7fff_ffff_ffff_ffff);

    // Restart
    bus.screen_state_i = 3'd0;
    tick(NONE);
    check_cleared("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/minesweeper_play.md
Name: minesweeper_play

Overview:
- Gameplay core of the 8x8 MineSweeper: owns the cursor, revealed-cell map and win/lose status for one round.
- Takes debounced button codes and the screen state from the top-level FSM, and the mine map from the map generator.
- Outputs the cursor position and revealed map to the display, and the end status back to the screen FSM.

Parameters:
- MAP_HEIGHT, 8, rows (y).
- MAP_WIDTH, 8, columns (x); cell (x,y) maps to bit index y*8+x in every map vector.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- button_i  in  5  button code: NONE=5'b00000, UP=5'b00001, DOWN=5'b00010, LEFT=5'b00100, RIGHT=5'b01000, MID=5'b10000
- screen_state_i  in  3  screen state: GAME_START=3'd0, GAME_PLAY=3'd1, other codes = non-play screens
- map_i  in  64  mine map, 1 = mine; held stable for the whole round
- x_pos_o  out  3  cursor column
- y_pos_o  out  3  cursor row
- play_end  out  2  00 playing, 01 lost, 10 won (11 never driven)
- map_shown_o  out  64  revealed map, 1 = revealed

Behaviour:
- Reset: x_pos_o=0, y_pos_o=0, play_end=00, map_shown_o=0, previous-button register=NONE.
- GAME_START applies the same clear as reset, every cycle it is present.
- Non-play screens other than GAME_START freeze all state.
- Button edge detection:
  - An action fires only on the cycle button_i is a valid code different from NONE and the previous-cycle sample was NONE.
  - Holding a button gives one action.
  - Invalid or multi-hot codes are ignored.
- Actions are taken only when screen_state_i==GAME_PLAY and play_end==00. Result is registered, visible one cycle after the sampling edge.
- Cursor moves:
  - UP: y-1. DOWN: y+1. LEFT: x-1. RIGHT: x+1.
  - Saturate at 0 and 7; no wrap.
- MID at cursor cell c:
  - Cell c already revealed: no effect.
  - map_i[c]==1 (mine): next cycle play_end=01 and map_shown_o |= map_i | (1<<c), i.e. all mines shown. Lose is final until GAME_START or reset.
  - Otherwise: next cycle map_shown_o[c]=1.
- Zero-cell flood expansion, combinational per cycle:
  - zero[i]=1 when cell i is not a mine and none of its up to 8 in-map neighbours is a mine. Edge and corner cells use only in-map neighbours.
  - Each cycle in GAME_PLAY with play_end==00: map_shown_o gains every in-map neighbour of every revealed cell with zero[i]=1.
  - The region grows one ring per cycle; it is stable within 16 cycles.
  - Expansion never reveals a mine, since mines always have nonzero neighbours.
- Win:
  - Registered check: when play_end==00 and (~map_i & ~map_shown_o)==0, play_end=10 on the next edge.
  - A lose detected on the same edge takes priority.
  - Once play_end≠00, buttons and expansion are ignored.
- Outputs are direct register outputs, with no combinational path from inputs.
- Map bits are never cleared except by reset or GAME_START.

Test Plan:
- Reset and start:
  - Stimulus: rst=1 for 1 cycle, then screen_state_i=GAME_START, then GAME_PLAY, with map_i=64'h6fcb_9f0a_b100_9080.
  - Required: x=0, y=0, play_end=00, map_shown_o=0.
- Movement and edges:
  - Stimulus: one-cycle DOWN, then RIGHT.
  - Required: (x,y)=(1,1) one cycle after the RIGHT sample.
  - Stimulus: LEFT x3.
  - Required: x=0, saturated.
  - Stimulus: hold DOWN for 5 cycles.
  - Required: y increments only once.
- Flood reveal:
  - Stimulus: MID at (1,1) on the map above, then wait 16 cycles.
  - Required: map_shown_o=64'h0000_0000_0E0F_0F0F, play_end=00.
- Single reveal then lose:
  - Stimulus: after reset, move to (1,3) and press MID.
  - Required: map_shown_o=64'h0000_0000_0200_0000, since (1,3) is a nonzero cell.
  - Stimulus: DOWN to (1,4), press MID.
  - Required: next cycle play_end=01 and map_shown_o=64'h6fcb_9f0a_b300_9080. Further MID or moves change nothing.
- Win:
  - Stimulus: map_i=64'h8000_0000_0000_0000, MID at (0,0).
  - Required: flood reveals all 63 safe cells; map_shown_o=64'h7fff_ffff_ffff_ffff; play_end=10 within 20 cycles.
- Freeze and restart:
  - Stimulus: screen_state_i=3'd2 mid-game, press buttons.
  - Required: no state change.
  - Stimulus: screen_state_i=GAME_START for 1 cycle.
  - Required: all outputs return to reset values.
